// File: rtl/windowing_pkg.sv
// Shared types and elaboration-time helpers for the stream windowing block.
// win_coeff() computes one quantised window coefficient; it is only ever
// evaluated at elaboration to fill the coefficient ROM.
package windowing_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    WIN_RECT     = 2'd0,
    WIN_HAMMING  = 2'd1,
    WIN_HANN     = 2'd2,
    WIN_BLACKMAN = 2'd3
  } window_mode_e;

  localparam real WIN_PI = 3.14159265358979323846;

  // Cosine by range reduction plus a long Taylor series, so elaboration does
  // not depend on tool support for $cos in constant functions.
  function automatic real cos_r(input real x);
    real a;
    real term;
    real sum;
    a = x;
    while (a > WIN_PI) a = a - 2.0 * WIN_PI;
    while (a < -WIN_PI) a = a + 2.0 * WIN_PI;
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k <= 20; k++) begin
      term = -term * a * a / real'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Coefficient n of an nn-point window in Q1.(cw-1), rounded to nearest and
  // clamped to [0, 1.0]. Rect is exactly 1.0.
  function automatic int win_coeff(input int mode, input int n, input int nn,
                                   input int cw);
    real x;
    real c;
    real one;
    int  res;
    one = real'(1 << (cw - 1));
    x   = real'(n) / real'(nn - 1);
    case (window_mode_e'(mode))
      WIN_HAMMING:  c = 0.54 - 0.46 * cos_r(2.0 * WIN_PI * x);
      WIN_HANN:     c = 0.5 - 0.5 * cos_r(2.0 * WIN_PI * x);
      WIN_BLACKMAN: c = 0.42 - 0.5 * cos_r(2.0 * WIN_PI * x)
                        + 0.08 * cos_r(4.0 * WIN_PI * x);
      default:      c = 1.0;
    endcase
    c = c * one;
    if (c <= 0.0) res = 0;
    else if (c >= one) res = 1 << (cw - 1);
    else res = $rtoi(c + 0.5);
    return res;
  endfunction

endpackage

// File: rtl/window_coeff_rom.sv
// Coefficient table for all four window shapes, addressed {mode, sample}.
// Contents are fixed at elaboration; the read is registered and advances
// only when the pipeline advances, forming the coefficient-fetch stage.
module window_coeff_rom
  import windowing_pkg::*;
#(
  parameter int FRAME_SIZE  = 256,
  parameter int COEFF_WIDTH = 16,
  parameter int SAMP_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [MODE_W+SAMP_W-1:0] addr,
  output logic [COEFF_WIDTH-1:0]   coeff
);

  localparam int ROWS  = 1 << SAMP_W;
  localparam int DEPTH = 4 * ROWS;

  logic [COEFF_WIDTH-1:0] rom_w [DEPTH];

  // Rows past FRAME_SIZE-1 (non power-of-two frames) are never addressed.
  for (genvar m = 0; m < 4; m++) begin : g_mode
    for (genvar n = 0; n < ROWS; n++) begin : g_samp
      localparam int WV = (n < FRAME_SIZE) ?
                          win_coeff(m, n, FRAME_SIZE, COEFF_WIDTH) : 0;
      assign rom_w[m * ROWS + n] = WV[COEFF_WIDTH-1:0];
    end
  end

  // Registered read, held while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coeff <= '0;
    end else if (en) begin
      coeff <= rom_w[addr];
    end
  end

endmodule

// File: rtl/stream_windowing.sv
// Sample-serial windowing stage with valid/ready on both sides.
// Pipeline: S1 coefficient fetch (ROM), S2 multiply, S3 round/saturate.
// Build option: define WINDOW_ROUND_EN to round half-up before the shift;
// otherwise the shift truncates toward minus infinity.
//
// Handshake: a beat moves when valid & ready are both high on a rising edge.
// All stages advance together on en = !out_valid | out_ready, so in_ready is
// combinational from out_ready, and out_* hold steady while stalled.
module stream_windowing
  import windowing_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int FRAME_SIZE   = 256,
  parameter int NUM_CHANNELS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MODE_W-1:0]     mode_i,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  frame_err
);

  localparam int SAW = $clog2(FRAME_SIZE);
  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PW  = DATA_WIDTH + COEFF_WIDTH + 1;

  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic           en;
  logic           accept;
  logic [CHW-1:0] chan_cnt;
  logic [SAW-1:0] samp_cnt;
  window_mode_e   mode_q;
  window_mode_e   mode_eff;
  logic           at_start;
  logic           at_final;
  logic           beat_last;
  logic           beat_err;

  logic                         s1_valid;
  logic signed [DATA_WIDTH-1:0] s1_data;
  logic [COEFF_WIDTH-1:0]       s1_coeff;
  logic                         s1_first;
  logic                         s1_last;

  logic                 s2_valid;
  logic signed [PW-1:0] s2_prod;
  logic                 s2_first;
  logic                 s2_last;

  logic signed [PW-1:0]         mul_a;
  logic signed [PW-1:0]         mul_b;
  logic signed [PW-1:0]         biased;
  logic signed [PW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] res;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en && !rst;
  assign accept    = in_valid && in_ready;
  assign at_start  = (samp_cnt == '0) && (chan_cnt == '0);
  assign at_final  = (samp_cnt == SAW'(FRAME_SIZE - 1)) &&
                     (chan_cnt == CHW'(NUM_CHANNELS - 1));
  assign beat_last = in_last || at_final;
  assign beat_err  = in_last ^ at_final;

  // The first beat of a frame uses mode_i directly; later beats use the latch.
  assign mode_eff  = at_start ? window_mode_e'(mode_i) : mode_q;

  window_coeff_rom #(
    .FRAME_SIZE (FRAME_SIZE),
    .COEFF_WIDTH(COEFF_WIDTH),
    .SAMP_W     (SAW)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .addr ({mode_eff, samp_cnt}),
    .coeff(s1_coeff)
  );

  // Frame position, per-frame mode latch and the framing-error pulse.
  // Any beat that ends a frame (final position or early in_last) resyncs to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_cnt  <= '0;
      samp_cnt  <= '0;
      mode_q    <= WIN_RECT;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && beat_err;
      if (accept) begin
        if (at_start) mode_q <= window_mode_e'(mode_i);
        if (beat_last) begin
          chan_cnt <= '0;
          samp_cnt <= '0;
        end else if (chan_cnt == CHW'(NUM_CHANNELS - 1)) begin
          chan_cnt <= '0;
          samp_cnt <= samp_cnt + SAW'(1);
        end else begin
          chan_cnt <= chan_cnt + CHW'(1);
        end
      end
    end
  end

  // S1: capture sample and frame flags alongside the ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_data  <= in_data;
      s1_first <= at_start;
      s1_last  <= beat_last;
    end
  end

  // Coefficient is unsigned, so it gets a zero sign bit before the multiply.
  assign mul_a = {{(PW-DATA_WIDTH){s1_data[DATA_WIDTH-1]}}, s1_data};
  assign mul_b = {{(PW-COEFF_WIDTH){1'b0}}, s1_coeff};

  // S2: full-precision signed product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_prod  <= mul_a * mul_b;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

`ifdef WINDOW_ROUND_EN
  localparam logic signed [PW-1:0] RND =
    {{(PW-COEFF_WIDTH+1){1'b0}}, 1'b1, {(COEFF_WIDTH-2){1'b0}}};
  assign biased = s2_prod + RND;
`else
  assign biased = s2_prod;
`endif

  assign shifted = biased >>> (COEFF_WIDTH - 1);

  // Clamp the rescaled product into the output sample range.
  always_comb begin
    res = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) res = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
  end

  // S3: output register; flags are qualified by valid so idle cycles read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_data  <= res;
      out_first <= s2_valid && s2_first;
      out_last  <= s2_valid && s2_last;
    end
  end

endmodule

// File: tb/tb_stream_windowing.sv
// Bench for stream_windowing (DW=16, CW=16, FRAME_SIZE=8, NUM_CHANNELS=2).
// Expected beats come from an independent position/mode/arithmetic model and
// are queued at acceptance, then popped as the DUT delivers them.
module tb_stream_windowing;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int FS = 8;
  localparam int NC = 2;
  localparam real TB_PI = 3.141592653589793;
`ifdef WINDOW_ROUND_EN
  localparam int HAM0_OUT = 800;
`else
  localparam int HAM0_OUT = 799;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode_i;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic          frame_err;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] out_log[$];
  int            m_samp = 0;
  int            m_chan = 0;
  logic [1:0]    m_mode = 2'd0;
  int            exp_err = 0;
  int            err_seen = 0;
  bit            rand_ready = 1'b0;
  bit            held = 1'b0;
  logic [DW+1:0] held_val;

  stream_windowing #(
    .DATA_WIDTH  (DW),
    .COEFF_WIDTH (CW),
    .FRAME_SIZE  (FS),
    .NUM_CHANNELS(NC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_i   (mode_i),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_first(out_first),
    .out_last (out_last),
    .frame_err(frame_err)
  );

  // ---------------- clock / back-pressure ----------------
  initial forever #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_coeff(input logic [1:0] md, input int n);
    real x;
    real c;
    x = real'(n) / real'(FS - 1);
    case (md)
      2'd1:    c = 0.54 - 0.46 * $cos(2.0 * TB_PI * x);
      2'd2:    c = 0.5 - 0.5 * $cos(2.0 * TB_PI * x);
      2'd3:    c = 0.42 - 0.5 * $cos(2.0 * TB_PI * x) + 0.08 * $cos(4.0 * TB_PI * x);
      default: c = 1.0;
    endcase
    c = c * 32768.0;
    if (c < 0.0) c = 0.0;
    if (c > 32768.0) c = 32768.0;
    return int'($floor(c + 0.5));
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic last, input logic [1:0] md);
    bit            start;
    bit            fin;
    int            w;
    longint        p;
    longint        q;
    logic [DW-1:0] r;
    start = (m_samp == 0) && (m_chan == 0);
    fin   = (m_samp == FS - 1) && (m_chan == NC - 1);
    if (start) m_mode = md;
    w = ref_coeff(m_mode, m_samp);
    p = longint'($signed(d)) * longint'(w);
`ifdef WINDOW_ROUND_EN
    p = p + 16384;
`endif
    q = p / 32768;
    if (p < 0 && (p % 32768) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    r = q[DW-1:0];
    exp_q.push_back({r, start, (last | fin)});
    if (last ^ fin) exp_err++;
    if (last | fin) begin
      m_samp = 0;
      m_chan = 0;
    end else if (m_chan == NC - 1) begin
      m_chan = 0;
      m_samp++;
    end else begin
      m_chan++;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          n_checks++;
          if (out_valid !== 1'b1 || {out_data, out_first, out_last} !== held_val)
            $display("FAIL stall_hold: got valid=%b beat=%h required valid=1 beat=%h",
                     out_valid, {out_data, out_first, out_last}, held_val);
          else n_pass++;
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_extra: got data=%0d with no beat expected", $signed(out_data));
          end else begin
            e = exp_q.pop_front();
            if ({out_data, out_first, out_last} !== e)
              $display("FAIL scoreboard: got data=%0d first=%b last=%b required data=%0d first=%b last=%b",
                       $signed(out_data), out_first, out_last,
                       $signed(e[DW+1:2]), e[1], e[0]);
            else n_pass++;
          end
          out_log.push_back(out_data);
        end
        if (frame_err === 1'b1) err_seen++;
        held     = out_valid && !out_ready;
        held_val = {out_data, out_first, out_last};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [1:0] md);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode_i   = md;
    #2;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end else begin
      model_accept(d, last, md);
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] md_a, input logic [1:0] md_b, input int switch_at,
                            input int nbeats, input int last_at, input int data_sel, input bit gaps);
    logic [DW-1:0] d;
    logic [DW-1:0] pat[3];
    pat[0] = 16'h7FFF;
    pat[1] = 16'h8000;
    pat[2] = 16'd1234;
    for (int i = 0; i < nbeats; i++) begin
      case (data_sel)
        1:       d = 16'd10000;
        2:       d = pat[i % 3];
        default: d = DW'($urandom_range(0, 65535));
      endcase
      if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
      send_beat(d, (i == last_at), (i < switch_at) ? md_a : md_b);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    mode_i = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, out_first, out_last, frame_err, in_ready} !== 5'b0)
      $display("FAIL reset_flags: got valid/first/last/err/ready=%b required 00000",
               {out_valid, out_first, out_last, frame_err, in_ready});
    else n_pass++;
    n_checks++;
    if (out_data !== '0) $display("FAIL reset_data: got %h required 0000", out_data);
    else n_pass++;
    rst = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_latency();
    rand_ready = 1'b0;
    send_beat(16'd1234, 1'b0, 2'd0);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL latency_c1: got valid=%b required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL latency_c2: got valid=%b required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd1234 || out_first !== 1'b1)
      $display("FAIL latency_c3: got valid=%b data=%0d first=%b required 1/1234/1",
               out_valid, out_data, out_first);
    else n_pass++;
    send_frame(2'd0, 2'd0, 0, 15, 14, 2, 1'b0);
    drain();
  endtask

  task automatic test_rect();
    send_frame(2'd0, 2'd0, 0, 16, 15, 2, 1'b0);
    send_frame(2'd0, 2'd0, 0, 16, 15, 2, 1'b0);
    drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rect_drain: got %0d pending required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (err_seen != exp_err) $display("FAIL rect_frame_err: got %0d pulses required %0d", err_seen, exp_err);
    else n_pass++;
  endtask

  task automatic test_hamming();
    out_log.delete();
    send_frame(2'd1, 2'd1, 0, 16, 15, 1, 1'b0);
    drain();
    n_checks++;
    if (out_log.size() < 2 || $signed(out_log[0]) != HAM0_OUT || $signed(out_log[1]) != HAM0_OUT)
      $display("FAIL hamming_s0: got %0d/%0d required %0d on both channels",
               (out_log.size() > 0) ? $signed(out_log[0]) : -1,
               (out_log.size() > 1) ? $signed(out_log[1]) : -1, HAM0_OUT);
    else n_pass++;
  endtask

  task automatic test_hann_blackman_mode();
    out_log.delete();
    send_frame(2'd2, 2'd2, 0, 16, 15, 0, 1'b0);
    send_frame(2'd1, 2'd3, 5, 16, 15, 0, 1'b0);
    send_frame(2'd3, 2'd3, 0, 16, 15, 0, 1'b0);
    drain();
    n_checks++;
    if (out_log.size() < 34 || out_log[0] !== '0 || out_log[1] !== '0)
      $display("FAIL hann_s0: got %0d beats first=%h required 0000", out_log.size(),
               (out_log.size() > 0) ? out_log[0] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (out_log.size() < 34 || out_log[32] !== '0 || out_log[33] !== '0)
      $display("FAIL blackman_s0: got %0d beats s0=%h required 0000", out_log.size(),
               (out_log.size() > 32) ? out_log[32] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL mode_drain: got %0d pending required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random_stall();
    rand_ready = 1'b1;
    for (int f = 0; f < 10; f++)
      send_frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3, 16, 15, 0, 1'b1);
    drain();
    rand_ready = 1'b0;
    drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL stall_drain: got %0d pending required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_framing();
    send_frame(2'd1, 2'd1, 0, 10, 9, 0, 1'b0);
    send_frame(2'd1, 2'd1, 0, 16, 15, 0, 1'b0);
    send_frame(2'd2, 2'd2, 0, 16, -1, 0, 1'b0);
    send_frame(2'd1, 2'd1, 0, 16, 15, 0, 1'b0);
    drain();
    n_checks++;
    if (err_seen != exp_err || exp_err != 2)
      $display("FAIL frame_err_count: got %0d pulses required %0d (model %0d)", err_seen, 2, exp_err);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL framing_drain: got %0d pending required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rand_ready = 1'b0;
    send_frame(2'd1, 2'd1, 0, 5, -1, 0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_first, out_last, in_ready} !== 4'b0)
      $display("FAIL reset_mid_outputs: got valid/first/last/ready=%b required 0000",
               {out_valid, out_first, out_last, in_ready});
    else n_pass++;
    exp_q.delete();
    m_samp = 0;
    m_chan = 0;
    m_mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame(2'd1, 2'd1, 0, 16, 15, 0, 1'b0);
    drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL reset_mid_drain: got %0d pending required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (err_seen != exp_err) $display("FAIL reset_mid_frame_err: got %0d pulses required %0d", err_seen, exp_err);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_rect();
    test_hamming();
    test_hann_blackman_mode();
    test_random_stall();
    test_framing();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
